// File: rtl/fetch_pc_predictor_pkg.sv
// Shared types for the fetch PC predictor: BTB counter encoding,
// entry layout for the default geometry and the counter step helper.
package fetch_pc_predictor_pkg;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_BTB_ENTRIES = 16;
    localparam int DEF_IDX_W       = $clog2(DEF_BTB_ENTRIES);
    localparam int DEF_TAG_W       = DEF_ADDR_W - 2 - DEF_IDX_W;

    localparam int INSTR_BYTES = 4;

    typedef logic [1:0] BtbCounter;

    localparam BtbCounter CTR_SNT = 2'b00;
    localparam BtbCounter CTR_WNT = 2'b01;
    localparam BtbCounter CTR_WT  = 2'b10;
    localparam BtbCounter CTR_ST  = 2'b11;

    typedef struct packed {
        logic                  valid;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_ADDR_W-1:0] target;
        BtbCounter             ctr;
    } BtbEntry;

    function automatic BtbCounter ctr_next(BtbCounter c, logic taken);
        BtbCounter n;
        n = c;
        if (taken) begin
            if (c != CTR_ST) n = c + 2'd1;
        end else begin
            if (c != CTR_SNT) n = c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/fetch_pc_predictor_if.sv
// Fetch-side bundle: hazard/redirect/resolution inputs from the
// pipeline and the fetch address plus prediction back out.
interface fetch_pc_predictor_if #(
    parameter int ADDR_W = 32
);

    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              update_valid;
    logic [ADDR_W-1:0] update_pc;
    logic              update_taken;
    logic [ADDR_W-1:0] update_target;
    logic [ADDR_W-1:0] current_pc;
    logic [ADDR_W-1:0] next_seq_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;

    modport master (
        output stall, redirect_valid, redirect_target,
        output update_valid, update_pc, update_taken, update_target,
        input  current_pc, next_seq_pc, pred_taken, pred_target
    );

    modport slave (
        input  stall, redirect_valid, redirect_target,
        input  update_valid, update_pc, update_taken, update_target,
        output current_pc, next_seq_pc, pred_taken, pred_target
    );

endinterface

// File: rtl/fetch_pc_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters;
// combinational lookup, one synchronous update port, word addressed.
module fetch_pc_predictor_btb
    import fetch_pc_predictor_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-3:0] lookup_word,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              update_valid,
    input  logic [ADDR_W-3:0] update_word,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        BtbCounter         ctr;
    } entry_t;

    entry_t entries_q [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    assign lk_idx = lookup_word[IDX_W-1:0];
    assign lk_tag = lookup_word[ADDR_W-3:IDX_W];
    assign lk_hit = entries_q[lk_idx].valid &&
                    (entries_q[lk_idx].tag == lk_tag);

    assign pred_taken  = lk_hit && entries_q[lk_idx].ctr[1];
    assign pred_target = lk_hit ? entries_q[lk_idx].target : '0;

    assign up_idx = update_word[IDX_W-1:0];
    assign up_tag = update_word[ADDR_W-3:IDX_W];
    assign up_hit = entries_q[up_idx].valid &&
                    (entries_q[up_idx].tag == up_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                entries_q[i].valid  <= 1'b0;
                entries_q[i].tag    <= '0;
                entries_q[i].target <= '0;
                entries_q[i].ctr    <= CTR_WNT;
            end
        end else if (update_valid) begin
            if (up_hit) begin
                entries_q[up_idx].ctr <=
                    ctr_next(entries_q[up_idx].ctr, update_taken);
                if (update_taken)
                    entries_q[up_idx].target <= update_target;
            end else if (update_taken) begin
                // A taken miss evicts whatever alias sits at this index
                entries_q[up_idx].valid  <= 1'b1;
                entries_q[up_idx].tag    <= up_tag;
                entries_q[up_idx].target <= update_target;
                entries_q[up_idx].ctr    <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/fetch_pc_predictor.sv
// Fetch PC register with stall, execute redirect and BTB-driven
// prediction of the next fetch address.
module fetch_pc_predictor
    import fetch_pc_predictor_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                BTB_ENTRIES  = DEF_BTB_ENTRIES,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input logic                clk,
    input logic                reset,
    fetch_pc_predictor_if.slave bus
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] seq_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              unused_lsb;

    assign seq_pc     = pc_q + ADDR_W'(INSTR_BYTES);
    assign unused_lsb = ^bus.update_pc[1:0];

    fetch_pc_predictor_btb #(
        .ADDR_W      (ADDR_W),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk           (clk),
        .reset         (reset),
        .lookup_word   (pc_q[ADDR_W-1:2]),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .update_valid  (bus.update_valid),
        .update_word   (bus.update_pc[ADDR_W-1:2]),
        .update_taken  (bus.update_taken),
        .update_target (bus.update_target)
    );

    always_ff @(posedge clk) begin
        if (reset)
            pc_q <= RESET_VECTOR;
        else if (bus.redirect_valid)
            pc_q <= bus.redirect_target;
        else if (bus.stall)
            pc_q <= pc_q;
        else if (pred_taken)
            pc_q <= pred_target;
        else
            pc_q <= seq_pc;
    end

    assign bus.current_pc  = pc_q;
    assign bus.next_seq_pc = seq_pc;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench for fetch_pc_predictor: 32-bit/16-entry instance
// plus an 8-bit instance for address wrap.
module tb_fetch_pc_predictor;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fetch_pc_predictor_if #(.ADDR_W(32)) bus_a ();
    fetch_pc_predictor_if #(.ADDR_W(8))  bus_b ();

    fetch_pc_predictor #(
        .ADDR_W       (32),
        .BTB_ENTRIES  (16),
        .RESET_VECTOR (32'h0)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    fetch_pc_predictor #(
        .ADDR_W       (8),
        .BTB_ENTRIES  (16),
        .RESET_VECTOR (8'h0)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [31:0] pc,
                         input logic pt, input logic [31:0] tgt);
        check({tag, ".pc"}, bus_a.current_pc, pc);
        check({tag, ".seq"}, bus_a.next_seq_pc, pc + 32'd4);
        check({tag, ".pt"}, 32'(bus_a.pred_taken), 32'(pt));
        check({tag, ".tgt"}, bus_a.pred_target, tgt);
    endtask

    task automatic set_redirect(input logic v, input logic [31:0] t);
        bus_a.redirect_valid  = v;
        bus_a.redirect_target = t;
    endtask

    task automatic set_update(input logic v, input logic [31:0] pc,
                              input logic tk, input logic [31:0] t);
        bus_a.update_valid  = v;
        bus_a.update_pc     = pc;
        bus_a.update_taken  = tk;
        bus_a.update_target = t;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus_a.stall = 1'b0;
        set_redirect(1'b0, 32'h0);
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        bus_b.stall           = 1'b0;
        bus_b.redirect_valid  = 1'b0;
        bus_b.redirect_target = 8'h0;
        bus_b.update_valid    = 1'b0;
        bus_b.update_pc       = 8'h0;
        bus_b.update_taken    = 1'b0;
        bus_b.update_target   = 8'h0;

        tick();
        tick();
        chk_a("reset", 32'h0, 1'b0, 32'h0);
        check("reset_b.pc", 32'(bus_b.current_pc), 32'h0);
        reset = 1'b0;

        // free run from the reset vector
        tick(); chk_a("run4", 32'h4, 1'b0, 32'h0);
        tick(); chk_a("run8", 32'h8, 1'b0, 32'h0);

        // stall holds, release resumes, redirect beats stall
        bus_a.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_a("stall", 32'h8, 1'b0, 32'h0);
        end
        bus_a.stall = 1'b0;
        tick(); chk_a("release", 32'hC, 1'b0, 32'h0);
        bus_a.stall = 1'b1;
        set_redirect(1'b1, 32'h40);
        tick(); chk_a("redir_stall", 32'h40, 1'b0, 32'h0);
        bus_a.stall = 1'b0;
        set_redirect(1'b0, 32'h0);

        // allocate 0x10 -> 0x4 and loop through it
        set_update(1'b1, 32'h10, 1'b1, 32'h4);
        tick(); chk_a("alloc", 32'h44, 1'b0, 32'h0);
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        set_redirect(1'b1, 32'h8);
        tick(); chk_a("loop8", 32'h8, 1'b0, 32'h0);
        set_redirect(1'b0, 32'h0);
        tick(); chk_a("loopC", 32'hC, 1'b0, 32'h0);
        tick(); chk_a("loop10", 32'h10, 1'b1, 32'h4);
        tick(); chk_a("loop4", 32'h4, 1'b0, 32'h0);
        tick(); tick();
        tick(); chk_a("loop10b", 32'h10, 1'b1, 32'h4);
        tick(); chk_a("loop4b", 32'h4, 1'b0, 32'h0);

        // counter walk: 10 -> 01 -> 00 (sat) -> 01 -> 10
        set_redirect(1'b1, 32'h10);
        set_update(1'b1, 32'h10, 1'b0, 32'h0);
        tick(); chk_a("nt1", 32'h10, 1'b0, 32'h4);
        set_redirect(1'b0, 32'h0);
        bus_a.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_a("nt_sat", 32'h10, 1'b0, 32'h4);
        end
        set_update(1'b1, 32'h10, 1'b1, 32'h20);
        tick(); chk_a("t1", 32'h10, 1'b0, 32'h20);
        tick(); chk_a("t2", 32'h10, 1'b1, 32'h20);
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        bus_a.stall = 1'b0;
        tick(); chk_a("t_follow", 32'h20, 1'b0, 32'h0);

        // aliasing at index 4, old contents visible in the update cycle
        bus_a.stall = 1'b1;
        set_redirect(1'b1, 32'h10);
        tick(); chk_a("alias_pre", 32'h10, 1'b1, 32'h20);
        set_redirect(1'b0, 32'h0);
        set_update(1'b1, 32'h50, 1'b1, 32'h80);
        #1; chk_a("same_cycle", 32'h10, 1'b1, 32'h20);
        tick(); chk_a("alias_miss", 32'h10, 1'b0, 32'h0);
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        set_redirect(1'b1, 32'h50);
        tick(); chk_a("alias_hit", 32'h50, 1'b1, 32'h80);
        set_redirect(1'b0, 32'h0);
        bus_a.stall = 1'b0;
        tick(); chk_a("alias_go", 32'h80, 1'b0, 32'h0);

        // unaligned redirect target taken verbatim
        set_redirect(1'b1, 32'h42);
        tick(); chk_a("unaligned", 32'h42, 1'b0, 32'h0);

        // reset discards concurrent redirect and update
        reset = 1'b1;
        set_redirect(1'b1, 32'h50);
        set_update(1'b1, 32'h90, 1'b1, 32'h100);
        tick(); chk_a("rst_mid", 32'h0, 1'b0, 32'h0);
        reset = 1'b0;
        set_update(1'b0, 32'h0, 1'b0, 32'h0);
        bus_a.stall = 1'b1;
        tick(); chk_a("rst_50", 32'h50, 1'b0, 32'h0);
        set_redirect(1'b1, 32'h90);
        tick(); chk_a("rst_90", 32'h90, 1'b0, 32'h0);
        set_redirect(1'b1, 32'h10);
        tick(); chk_a("rst_10", 32'h10, 1'b0, 32'h0);

        // 32-bit wrap
        set_redirect(1'b1, 32'hFFFF_FFFC);
        tick();
        check("wrap32.pc", bus_a.current_pc, 32'hFFFF_FFFC);
        check("wrap32.seq", bus_a.next_seq_pc, 32'h0);
        set_redirect(1'b0, 32'h0);
        bus_a.stall = 1'b0;
        tick();
        check("wrap32.next", bus_a.current_pc, 32'h0);

        // 8-bit wrap
        bus_b.stall           = 1'b1;
        bus_b.redirect_valid  = 1'b1;
        bus_b.redirect_target = 8'hFC;
        tick();
        check("wrap8.pc", 32'(bus_b.current_pc), 32'hFC);
        check("wrap8.seq", 32'(bus_b.next_seq_pc), 32'h00);
        check("wrap8.pt", 32'(bus_b.pred_taken), 32'h0);
        bus_b.stall          = 1'b0;
        bus_b.redirect_valid = 1'b0;
        tick();
        check("wrap8.next", 32'(bus_b.current_pc), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
